hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Sequences the 5-stage MIPS pipeline around hazards the forwarding unit cannot resolve: load-use, branch-in-ID operand dependencies, taken-branch/jump flush, and multi-cycle data-memory waits.
- Drives PC/IF_ID write enables, the ID_EX bubble, the IF_ID flush and a global freeze.
- Sits beside the forwarding unit in the ID stage; forwarding covers EX_MEM→EX, MEM_WB→EX and EX_MEM→branch comparator only.

Parameters:
- REG_W, 5, register-specifier width.
- STAT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegWrite  in  1  instruction in EX writes a register
- ID_EX_RegisterRd  in  REG_W  EX destination, after the RegDst mux
- EX_MEM_MemRead  in  1  instruction in MEM is a load
- EX_MEM_MemWrite  in  1  instruction in MEM is a store
- EX_MEM_RegisterRd  in  REG_W  MEM destination
- IF_ID_RegisterRs  in  REG_W  ID source rs
- IF_ID_RegisterRt  in  REG_W  ID source rt
- IF_ID_UsesRt  in  1  ID instruction reads rt
- IF_ID_Branch  in  1  beq/bne in ID
- branch_taken  in  1  ID comparator result, qualified by IF_ID_Branch
- jump  in  1  j/jal in ID
- dmem_ack  in  1  data memory completes the current access
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF_ID load enable
- id_ex_bubble  out  1  zero ID_EX control bits
- if_id_flush  out  1  clear IF_ID
- pipe_freeze  out  1  hold every pipeline register

Behaviour:
- FSM states: RUN, HOLD, FREEZE. 2-bit stall_cnt.
- Reset (async, rst_n=0): state=RUN, stall_cnt=0.
  - Outputs are decoded from state and inputs.
  - With idle inputs: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pipe_freeze=0.
- Match rule: a destination d matches when d≠0 and (d==Rs, or (IF_ID_UsesRt and d==Rt)).
- Hazard classes, evaluated in RUN:
  - LU: ID_EX_MemRead, ID_EX_RegisterRd matches, IF_ID_Branch=0 → 1 stall.
  - BA: IF_ID_Branch, ID_EX_RegWrite, !ID_EX_MemRead, ID_EX_RegisterRd matches → 1 stall.
  - BL: IF_ID_Branch, ID_EX_MemRead, ID_EX_RegisterRd matches → 2 stalls.
  - BM: IF_ID_Branch, EX_MEM_MemRead, EX_MEM_RegisterRd matches → 1 stall.
- Stall cycle outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - RUN with any hazard: stall this cycle. Load stall_cnt=N-1 (BL wins over others). If N-1>0, go to HOLD; else stay in RUN.
  - HOLD: stall. Decrement stall_cnt; at 0 return to RUN. No hazard re-evaluation in HOLD.
- Flush: in RUN with no hazard, (IF_ID_Branch & branch_taken) | jump → if_id_flush=1 for exactly that cycle.
  - A branch that is stalled never flushes until its final, hazard-free RUN cycle.
- Memory wait: EX_MEM_MemRead|EX_MEM_MemWrite with dmem_ack=0 → pipe_freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0.
  - Go to FREEZE, remembering the previous state (RUN/HOLD) and stall_cnt.
  - FREEZE holds until dmem_ack=1, then returns to the saved state. stall_cnt does not decrement while frozen.
  - Freeze has priority over stall and flush in every state.
- Ack in the same cycle as the request: no freeze.
- rst_n asserted mid-HOLD/FREEZE: immediate return to RUN, stall_cnt=0.
- Register 0 is never a hazard.

Optional Feature:
- HAZ_STATS_EN defined: adds outputs stat_stall (STAT_W), stat_flush (STAT_W), stat_freeze (STAT_W).
  - Incremented per stall cycle, per flush cycle and per freeze cycle respectively.
  - Saturate at all-ones; cleared by reset.
- HAZ_STATS_EN undefined: no counters, no extra ports.

Test Plan:
- lw $2 in EX (ID_EX_MemRead=1, Rd=2); add in ID with Rs=2 → 1 cycle pc_write=0, id_ex_bubble=1; next cycle pc_write=1, state RUN.
- lw $3 in EX; beq in ID with Rt=3, UsesRt=1 → 2 consecutive stall cycles (RUN→HOLD→RUN); then branch_taken=1 → if_id_flush=1 in the 3rd cycle only.
- add $4 in EX (RegWrite=1); beq in ID with Rs=4 → exactly 1 stall. Same case with Rd=0 → no stall.
- Store in MEM, dmem_ack low for 3 cycles → pipe_freeze=1 for 3 cycles, other enables 0; resumes on ack. Same request with ack on the first cycle → no freeze.
- Freeze raised during HOLD with stall_cnt=1 → after ack, exactly 1 further stall cycle, then RUN.
- jump=1, no hazard → if_id_flush=1 for one cycle. With HAZ_STATS_EN, stat_flush goes 0→1; reset mid-FREEZE clears all stats and state.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle for the hazard/stall controller.
// Statistics outputs exist only when HAZ_STATS_EN is defined.
interface hazard_stall_controller_if #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned STAT_W = 32
);
  logic             ID_EX_MemRead;
  logic             ID_EX_RegWrite;
  logic [REG_W-1:0] ID_EX_RegisterRd;
  logic             EX_MEM_MemRead;
  logic             EX_MEM_MemWrite;
  logic [REG_W-1:0] EX_MEM_RegisterRd;
  logic [REG_W-1:0] IF_ID_RegisterRs;
  logic [REG_W-1:0] IF_ID_RegisterRt;
  logic             IF_ID_UsesRt;
  logic             IF_ID_Branch;
  logic             branch_taken;
  logic             jump;
  logic             dmem_ack;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             pipe_freeze;
`ifdef HAZ_STATS_EN
  logic [STAT_W-1:0] stat_stall;
  logic [STAT_W-1:0] stat_flush;
  logic [STAT_W-1:0] stat_freeze;
`endif

  modport master (
    output ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegisterRd,
    output EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegisterRd,
    output IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt, IF_ID_Branch,
    output branch_taken, jump, dmem_ack,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze
`ifdef HAZ_STATS_EN
    , input stat_stall, stat_flush, stat_freeze
`endif
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegisterRd,
    input  EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegisterRd,
    input  IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt, IF_ID_Branch,
    input  branch_taken, jump, dmem_ack,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze
`ifdef HAZ_STATS_EN
    , output stat_stall, stat_flush, stat_freeze
`endif
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush/freeze sequencer for the 5-stage MIPS pipeline (ID stage).
// Optional saturating event counters are enabled with HAZ_STATS_EN.
module hazard_stall_controller #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned STAT_W = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  hazard_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {StRun, StHold, StFreeze} state_e;

  state_e     state_q, saved_q, eff_state;
  logic [1:0] stall_cnt_q;
  logic [1:0] stall_load;
  logic       mem_busy, ex_match, mem_match;
  logic       haz_lu, haz_ba, haz_bl, haz_bm, hazard;
  logic       stall, flush;

  function automatic logic dest_match(input logic [REG_W-1:0] d,
                                      input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt,
                                      input logic             uses_rt);
    return (d != '0) && ((d == rs) || (uses_rt && (d == rt)));
  endfunction

  always_comb begin
    mem_busy  = (bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite) & ~bus.dmem_ack;
    ex_match  = dest_match(bus.ID_EX_RegisterRd, bus.IF_ID_RegisterRs,
                           bus.IF_ID_RegisterRt, bus.IF_ID_UsesRt);
    mem_match = dest_match(bus.EX_MEM_RegisterRd, bus.IF_ID_RegisterRs,
                           bus.IF_ID_RegisterRt, bus.IF_ID_UsesRt);
    haz_lu = bus.ID_EX_MemRead & ex_match & ~bus.IF_ID_Branch;
    haz_ba = bus.IF_ID_Branch & bus.ID_EX_RegWrite & ~bus.ID_EX_MemRead & ex_match;
    haz_bl = bus.IF_ID_Branch & bus.ID_EX_MemRead & ex_match;
    haz_bm = bus.IF_ID_Branch & bus.EX_MEM_MemRead & mem_match;
    hazard = haz_lu | haz_ba | haz_bl | haz_bm;
    // Remaining stall cycles after this one; only branch-after-load needs two.
    stall_load = haz_bl ? 2'd1 : 2'd0;
  end

  // The ack cycle of a freeze behaves like the state that was interrupted.
  always_comb begin
    eff_state = (state_q == StFreeze) ? saved_q : state_q;
  end

  always_comb begin
    stall = ~mem_busy & ((eff_state == StHold) | ((eff_state == StRun) & hazard));
    flush = ~mem_busy & (eff_state == StRun) & ~hazard &
            ((bus.IF_ID_Branch & bus.branch_taken) | bus.jump);
    bus.pipe_freeze  = mem_busy;
    bus.pc_write     = ~mem_busy & ~stall;
    bus.if_id_write  = ~mem_busy & ~stall;
    bus.id_ex_bubble = stall;
    bus.if_id_flush  = flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      saved_q     <= StRun;
      stall_cnt_q <= 2'd0;
    end else if (mem_busy) begin
      state_q <= StFreeze;
      saved_q <= eff_state;
    end else begin
      case (eff_state)
        StHold: begin
          if (stall_cnt_q <= 2'd1) begin
            stall_cnt_q <= 2'd0;
            state_q     <= StRun;
          end else begin
            stall_cnt_q <= stall_cnt_q - 2'd1;
            state_q     <= StHold;
          end
        end
        default: begin
          if (hazard) begin
            stall_cnt_q <= stall_load;
            state_q     <= (stall_load != 2'd0) ? StHold : StRun;
          end else begin
            state_q <= StRun;
          end
        end
      endcase
    end
  end

`ifdef HAZ_STATS_EN
  logic [STAT_W-1:0] stat_stall_q, stat_flush_q, stat_freeze_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_q  <= '0;
      stat_flush_q  <= '0;
      stat_freeze_q <= '0;
    end else begin
      if (stall && !(&stat_stall_q))     stat_stall_q  <= stat_stall_q + STAT_W'(1);
      if (flush && !(&stat_flush_q))     stat_flush_q  <= stat_flush_q + STAT_W'(1);
      if (mem_busy && !(&stat_freeze_q)) stat_freeze_q <= stat_freeze_q + STAT_W'(1);
    end
  end

  always_comb begin
    bus.stat_stall  = stat_stall_q;
    bus.stat_flush  = stat_flush_q;
    bus.stat_freeze = stat_freeze_q;
  end
`endif

endmodule
